fifo_rr_arbiter: RTL and testbench

- Shares one synchronous FIFO buffer between NUM_REQ producers using round-robin arbitration.
- Each accepted word is stored with the index of the producer that sent it.
- A single consumer drains the buffer over a valid/ready interface.
- Sits in front of the FIFO datapath so that several sources can feed one buffered stream without contention.

---
 rtl/fifo_arb_pkg.sv | 30 +++
 rtl/fifo_store.sv | 59 +++++
 rtl/fifo_rr_arbiter.sv | 74 +++++++
 tb/tb_fifo_rr_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared configuration, entry format and round-robin pick function for the
// multi-producer FIFO arbiter.
package fifo_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 5;
  localparam int FIFO_DEPTH = 8;

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [SRC_W-1:0]      src;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // One-hot grant for the first valid requester at or after ptr, wrapping.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                  input logic [SRC_W-1:0]   ptr);
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   idx;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx] && (grant == '0)) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/fifo_store.sv
// Synchronous show-ahead FIFO storage. Pointers carry an extra wrap bit;
// occupancy is kept in a register so full/empty come straight from flops.
module fifo_store
  import fifo_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [PTR_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int IDX_W = PTR_W - 1;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q, count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == PTR_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[IDX_W-1:0]] <= push_entry_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rptr_q[IDX_W-1:0]];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter feeding one shared show-ahead FIFO; each stored word
// remembers which requester produced it.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready,
  output logic [PTR_W-1:0]              count,
  output logic                          full,
  output logic                          empty
);

  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  push, pop;
  entry_t                push_entry, head;

  // Full is a registered flag, so accepting never depends on the same-cycle pop.
  assign grant     = rr_pick(req_valid, rr_ptr_q);
  assign req_ready = (rst || full) ? '0 : grant;
  assign push      = |req_ready;

  // Encode the one-hot grant and select the winning payload.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = SRC_W'(i);
        gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Priority moves just past the requester that was served; holds otherwise.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign push_entry = '{src: gnt_idx, data: gnt_data};
  assign pop        = out_valid && out_ready;

  fifo_store u_store (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_src   = head.src;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed vector table plus randomized traffic,
// both checked against a queue-based reference model.
module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;

  localparam int RDW = NUM_REQ * DATA_WIDTH;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [RDW-1:0]       req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [SRC_W-1:0]     out_src;
  logic                 out_ready;
  logic [PTR_W-1:0]     count;
  logic                 full;
  logic                 empty;

  fifo_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A requester that is waiting must keep its payload steady.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stable
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[gi] && !req_ready[gi]) |=>
        (!req_valid[gi] || $stable(req_data[gi*DATA_WIDTH +: DATA_WIDTH])));
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int src;
    int data;
  } ment_t;
  ment_t mq[$];
  int    m_rr;

  typedef struct {
    logic               r;
    logic [NUM_REQ-1:0] rv;
    logic               ordy;
    logic [NUM_REQ-1:0] ready;
    int                 cnt;
    logic               ov;
    int                 src;
    int                 data;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [NUM_REQ-1:0] rv, input logic ordy,
                              input logic [NUM_REQ-1:0] ready, input int cnt, input logic ov,
                              input int src, input int data);
    vec_t v;
    v.r = r; v.rv = rv; v.ordy = ordy; v.ready = ready;
    v.cnt = cnt; v.ov = ov; v.src = src; v.data = data;
    tbl.push_back(v);
  endfunction

  // Apply one cycle of inputs, check DUT against the model, then advance the model.
  task automatic cycle(input logic r, input logic [NUM_REQ-1:0] rv, input logic [RDW-1:0] rd,
                       input logic ordy, output logic [NUM_REQ-1:0] a_ready, output int a_count,
                       output logic a_ov, output int a_src, output int a_data);
    int g;
    int idx;
    int sz;
    logic [NUM_REQ-1:0] e_ready;
    logic [RDW-1:0] sh;
    ment_t e;
    rst = r; req_valid = rv; req_data = rd; out_ready = ordy;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_rr + k) % NUM_REQ;
      if (g < 0 && rv[idx]) g = idx;
    end
    sz = mq.size();
    e_ready = '0;
    if (!r && g >= 0 && sz < FIFO_DEPTH) e_ready[g] = 1'b1;
    chk("req_ready", int'(req_ready), int'(e_ready));
    chk("count", int'(count), sz);
    chk("full", int'(full), int'(sz == FIFO_DEPTH));
    chk("empty", int'(empty), int'(sz == 0));
    chk("out_valid", int'(out_valid), int'(sz > 0));
    chk("out_src", int'(out_src), (sz > 0) ? mq[0].src : 0);
    chk("out_data", int'(out_data), (sz > 0) ? mq[0].data : 0);
    a_ready = req_ready; a_count = int'(count); a_ov = out_valid;
    a_src = int'(out_src); a_data = int'(out_data);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_rr = 0;
    end else begin
      if (sz > 0 && ordy) void'(mq.pop_front());
      if (e_ready != '0) begin
        sh = rd >> (g * DATA_WIDTH);
        e.src  = g;
        e.data = int'(sh[DATA_WIDTH-1:0]);
        mq.push_back(e);
        m_rr = (g + 1) % NUM_REQ;
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RDW-1:0]       fixed_d;
    logic [NUM_REQ-1:0]   a_ready;
    int                   a_count, a_src, a_data;
    logic                 a_ov;
    logic [NUM_REQ-1:0]   hv;
    logic [DATA_WIDTH-1:0] hd [NUM_REQ];
    logic [NUM_REQ-1:0]   rv;
    logic [RDW-1:0]       rd;
    logic                 r, ordy;

    fixed_d = {5'd13, 5'd12, 5'd11, 5'd10};

    // Idle after reset.
    repeat (3) add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // All four requesting: served 0,1,2,3; then drain in order.
    add(0, 4'b1111, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 0, 10);
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 0, 10);
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, 10);
    add(0, 4'b0000, 1, 4'b0000, 4, 1, 0, 10);
    add(0, 4'b0000, 1, 4'b0000, 3, 1, 1, 11);
    add(0, 4'b0000, 1, 4'b0000, 2, 1, 2, 12);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 3, 13);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // Only 2, then 1 and 3: 3 wins before 1.
    add(0, 4'b0100, 0, 4'b0100, 0, 0, 0, 0);
    add(0, 4'b1010, 0, 4'b1000, 1, 1, 2, 12);
    add(0, 4'b1010, 0, 4'b0010, 2, 1, 2, 12);
    add(0, 4'b0000, 1, 4'b0000, 3, 1, 2, 12);
    add(0, 4'b0000, 1, 4'b0000, 2, 1, 3, 13);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 1, 11);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // Fill to eight starting from priority 2.
    add(0, 4'b1111, 0, 4'b0100, 0, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 1, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0001, 2, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0010, 3, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0100, 4, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b1000, 5, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0001, 6, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0010, 7, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0000, 8, 1, 2, 12);
    // Full with pop: pop only, then push alongside pop.
    add(0, 4'b0001, 1, 4'b0000, 8, 1, 2, 12);
    add(0, 4'b0001, 1, 4'b0001, 7, 1, 3, 13);
    add(0, 4'b0000, 0, 4'b0000, 7, 1, 0, 10);
    add(0, 4'b0000, 1, 4'b0000, 7, 1, 0, 10);
    add(0, 4'b0000, 1, 4'b0000, 6, 1, 1, 11);
    add(0, 4'b0000, 0, 4'b0000, 5, 1, 2, 12);
    // Reset with five queued: everything dropped, priority back to 0.
    add(1, 4'b1111, 0, 4'b0000, 5, 1, 2, 12);
    add(0, 4'b1111, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 0, 10);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);

    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    m_rr = 0;

    foreach (tbl[n]) begin
      cycle(tbl[n].r, tbl[n].rv, fixed_d, tbl[n].ordy, a_ready, a_count, a_ov, a_src, a_data);
      chk($sformatf("vec%0d.ready", n), int'(a_ready), int'(tbl[n].ready));
      chk($sformatf("vec%0d.count", n), a_count, tbl[n].cnt);
      chk($sformatf("vec%0d.valid", n), int'(a_ov), int'(tbl[n].ov));
      chk($sformatf("vec%0d.src", n), a_src, tbl[n].src);
      chk($sformatf("vec%0d.data", n), a_data, tbl[n].data);
    end

    // Randomized traffic: first a saturated stretch, then sparse requests with rare resets.
    hv = '0;
    for (int i = 0; i < NUM_REQ; i++) hd[i] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hv[i] && (c < 60 || $urandom_range(0, 2) == 0)) begin
          hv[i] = 1'b1;
          hd[i] = DATA_WIDTH'($urandom);
        end
      end
      rv = hv;
      rd = '0;
      for (int i = 0; i < NUM_REQ; i++) rd[i*DATA_WIDTH +: DATA_WIDTH] = hd[i];
      ordy = ($urandom_range(0, 3) != 0);
      r    = (c > 60) && ($urandom_range(0, 79) == 0);
      cycle(r, rv, rd, ordy, a_ready, a_count, a_ov, a_src, a_data);
      for (int i = 0; i < NUM_REQ; i++) if (a_ready[i]) hv[i] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
